// File: rtl/da_pkg.sv
// -----------------------------------------------------------------------------
// da_pkg
// Shared definitions for the distributed-arithmetic row accumulator: sample,
// ROM and accumulator widths, the fixed-point fraction width, the number of
// bit planes processed per sample set, and the controller state type.
// No ports (package).
// -----------------------------------------------------------------------------
package da_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ROM_W    = 16;
  localparam int ACC_W    = 32;
  localparam int FRAC_W   = 14;
  localparam int NPLANES  = 16;
  localparam int J_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } da_state_e;

endpackage

// File: rtl/da_row_accum_if.sv
// -----------------------------------------------------------------------------
// da_row_accum_if
// Bundles the sample-input handshake, the DA ROM port and the result
// handshake of da_row_accum.
//   in_valid/in_ready : sample set handshake, samples x0..x3 (signed 16-bit)
//   rom_addr/rom_cs   : DA ROM address {x1[j],x2[j],x3[j]} and chip select
//   rom_data          : signed Q2.14 ROM word, combinational on rom_addr
//   out_valid/out_ready/result : result handshake and signed 16-bit result
// Modports: slave = the accumulator, master = its environment.
// -----------------------------------------------------------------------------
interface da_row_accum_if;
  import da_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  logic signed [SAMPLE_W-1:0] x0;
  logic signed [SAMPLE_W-1:0] x1;
  logic signed [SAMPLE_W-1:0] x2;
  logic signed [SAMPLE_W-1:0] x3;
  logic [2:0]                 rom_addr;
  logic                       rom_cs;
  logic signed [ROM_W-1:0]    rom_data;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [SAMPLE_W-1:0] result;

  modport slave (
    input  in_valid, x0, x1, x2, x3, rom_data, out_ready,
    output in_ready, rom_addr, rom_cs, out_valid, result
  );

  modport master (
    output in_valid, x0, x1, x2, x3, rom_data, out_ready,
    input  in_ready, rom_addr, rom_cs, out_valid, result
  );

endinterface

// File: rtl/da_sat_round.sv
// -----------------------------------------------------------------------------
// da_sat_round
// Combinational conversion of the 32-bit accumulator to the 16-bit result:
// arithmetic shift right by FRAC_W, saturated to the signed 16-bit range.
// Configuration macro DA_ROW_ACCUM_ROUND_EN: when defined, 2^(FRAC_W-1) is
// added before the shift (round half up); otherwise the shift truncates.
// Ports:
//   acc_i    : signed accumulator value
//   result_o : signed saturated result
// -----------------------------------------------------------------------------
module da_sat_round
  import da_pkg::*;
(
  input  logic signed [ACC_W-1:0]    acc_i,
  output logic signed [SAMPLE_W-1:0] result_o
);

  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(SAMPLE_W-1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2**(SAMPLE_W-1)));
`ifdef DA_ROW_ACCUM_ROUND_EN
  localparam logic signed [ACC_W:0] HALF_LSB = (ACC_W+1)'(2**(FRAC_W-1));
`endif

  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] shifted;

  // One extra bit of headroom so the rounding bias can never wrap the sign.
  always_comb begin
`ifdef DA_ROW_ACCUM_ROUND_EN
    biased = $signed({acc_i[ACC_W-1], acc_i}) + HALF_LSB;
`else
    biased = $signed({acc_i[ACC_W-1], acc_i});
`endif
    shifted = biased >>> FRAC_W;
    if (shifted > SAT_MAX) begin
      result_o = SAT_MAX[SAMPLE_W-1:0];
    end else if (shifted < SAT_MIN) begin
      result_o = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      result_o = shifted[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/da_row_accum.sv
// -----------------------------------------------------------------------------
// da_row_accum
// Distributed-arithmetic row accumulator. A sample set x0..x3 is accepted in
// IDLE, then 16 bit planes are walked (LSB first) in ACCUM. Each plane reads
// the DA ROM at {x1[j],x2[j],x3[j]}, negates the word when x0[j] is set and
// adds it shifted by j; plane 15 is the two's-complement sign plane and is
// subtracted. The saturated result is registered on entry to DONE and held
// until the out_valid/out_ready handshake.
// Configuration macro DA_ROW_ACCUM_ROUND_EN selects rounding instead of
// truncation in the final shift (see da_sat_round).
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : da_row_accum_if.slave (sample, ROM and result handshakes)
// -----------------------------------------------------------------------------
module da_row_accum
  import da_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  da_row_accum_if.slave bus
);

  localparam logic [J_W-1:0] LAST_J = J_W'(NPLANES - 1);

  da_state_e                  state_q, state_d;
  logic signed [SAMPLE_W-1:0] x0_q, x0_d, x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [J_W-1:0]             j_q, j_d;
  logic signed [SAMPLE_W-1:0] result_q, result_d;
  logic signed [ACC_W-1:0]    term;
  logic signed [ACC_W-1:0]    acc_step;
  logic signed [SAMPLE_W-1:0] sat_result;

  // Contribution of the current bit plane; the sign plane carries weight -2^15.
  always_comb begin
    term = {{(ACC_W-ROM_W){bus.rom_data[ROM_W-1]}}, bus.rom_data};
    if (x0_q[j_q]) begin
      term = -term;
    end
    if (j_q == LAST_J) begin
      acc_step = acc_q - (term <<< j_q);
    end else begin
      acc_step = acc_q + (term <<< j_q);
    end
  end

  // The final result is taken from the accumulator value being written on the
  // last plane, so it is already registered when DONE is entered.
  da_sat_round u_sat_round (
    .acc_i    (acc_step),
    .result_o (sat_result)
  );

  // Controller: accept, walk 16 planes, hold the result until taken.
  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    x3_d     = x3_q;
    acc_d    = acc_q;
    j_d      = j_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          x0_d    = bus.x0;
          x1_d    = bus.x1;
          x2_d    = bus.x2;
          x3_d    = bus.x3;
          acc_d   = '0;
          j_d     = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        acc_d = acc_step;
        j_d   = j_q + J_W'(1);
        if (j_q == LAST_J) begin
          result_d = sat_result;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset clears everything including mid-accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      x0_q     <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      x3_q     <= '0;
      acc_q    <= '0;
      j_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      x3_q     <= x3_d;
      acc_q    <= acc_d;
      j_q      <= j_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.rom_cs    = (state_q == ST_ACCUM);
  assign bus.rom_addr  = (state_q == ST_ACCUM) ? {x1_q[j_q], x2_q[j_q], x3_q[j_q]} : 3'b000;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_da_row_accum.sv
// -----------------------------------------------------------------------------
// tb_da_row_accum
// Testbench for da_row_accum. A linear DA ROM built from three coefficients
// answers rom_addr combinationally; expected results come from a plane-by-plane
// arithmetic model of the distributed-arithmetic sum, evaluated with 64-bit
// integers. Honours DA_ROW_ACCUM_ROUND_EN in the model.
// -----------------------------------------------------------------------------
module tb_da_row_accum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  time  lastAccept = 0;

  // ROM word for address {a1,a2,a3} = a1*C1 + a2*C2 + a3*C3
  // with C1 = 8867, C2 = -6270, C3 = -15137.
  logic signed [15:0] romTable [8] = '{16'sd0, -16'sd15137, -16'sd6270, -16'sd21407,
                                       16'sd8867, -16'sd6270, 16'sd2597, -16'sd12540};

  da_row_accum_if bus ();

  da_row_accum dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb bus.rom_data = romTable[bus.rom_addr];

  // Sum over bit planes j of weight_j * (+/-)ROM[{x1[j],x2[j],x3[j]}], where
  // weight_j = 2^j for j < 15 and -2^15 for the sign plane, then scale by 2^-14.
  function automatic logic signed [15:0] modelResult(logic signed [15:0] a0, logic signed [15:0] a1,
                                                     logic signed [15:0] a2, logic signed [15:0] a3);
    longint acc = 0;
    longint t;
    longint weight;
    int     addr;
    for (int j = 0; j < 16; j++) begin
      addr   = int'({a1[j], a2[j], a3[j]});
      t      = longint'(romTable[addr]);
      if (a0[j]) t = -t;
      weight = (j == 15) ? -longint'(32768) : (longint'(1) << j);
      acc    = acc + t * weight;
    end
`ifdef DA_ROW_ACCUM_ROUND_EN
    acc = acc + 8192;
`endif
    acc = acc >>> 14;
    if (acc > 32767) return 16'sh7fff;
    if (acc < -32768) return 16'sh8000;
    return 16'(acc);
  endfunction

  // One complete transaction: accept, 16 planes, optional back-pressure, handshake.
  task automatic runSet(input logic signed [15:0] a0, input logic signed [15:0] a1,
                        input logic signed [15:0] a2, input logic signed [15:0] a3,
                        input logic signed [15:0] expRes, input int holdLow, input bit noise);
    int   lat;
    logic [2:0] expAddr;
    @(negedge clk);
    bus.x0 = a0; bus.x1 = a1; bus.x2 = a2; bus.x3 = a3;
    bus.in_valid  = 1'b1;
    bus.out_ready = (holdLow == 0);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL idle_in_ready got=%b want=1", bus.in_ready);
    end
    @(posedge clk);
    lastAccept = $time;
    #1;
    bus.in_valid = 1'b0;
    lat = -1;
    for (int n = 0; n < 40 && lat < 0; n++) begin
      if (bus.out_valid === 1'b1) begin
        lat = n;
      end else begin
        if (n < 16) begin
          expAddr = {a1[n], a2[n], a3[n]};
          total++;
          if (bus.rom_cs !== 1'b1 || bus.in_ready !== 1'b0 || bus.rom_addr !== expAddr) begin
            bad++;
            $display("[TB] FAIL accum_plane%0d got cs=%b rdy=%b addr=%b want cs=1 rdy=0 addr=%b",
                     n, bus.rom_cs, bus.in_ready, bus.rom_addr, expAddr);
          end
        end
        if (noise && n < 15) begin
          bus.in_valid = 1'($urandom_range(0, 1));
          bus.x0 = 16'($urandom); bus.x1 = 16'($urandom);
          bus.x2 = 16'($urandom); bus.x3 = 16'($urandom);
        end
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b0;
    // out_valid is expected on the 16th edge after the accept edge, i.e. in the
    // 17th cycle counting the accept cycle; this keeps the 18-cycle period.
    total++;
    if (lat != 16) begin
      bad++; $display("[TB] FAIL latency got=%0d want=16", lat);
    end
    total++;
    if (bus.result !== expRes) begin
      bad++; $display("[TB] FAIL result got=%0d want=%0d", bus.result, expRes);
    end
    for (int k = 0; k < holdLow; k++) begin
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.result !== expRes || bus.in_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL hold%0d got ov=%b res=%0d rdy=%b want ov=1 res=%0d rdy=0",
                 k, bus.out_valid, bus.result, bus.in_ready, expRes);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.rom_cs !== 1'b0 || bus.rom_addr !== 3'b000) begin
      bad++;
      $display("[TB] FAIL handshake got ov=%b rdy=%b cs=%b addr=%b want ov=0 rdy=1 cs=0 addr=000",
               bus.out_valid, bus.in_ready, bus.rom_cs, bus.rom_addr);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.x0 = '0; bus.x1 = '0; bus.x2 = '0; bus.x3 = '0;
    rst_n = 1'b0;
    #12;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.rom_cs !== 1'b0 ||
        bus.rom_addr !== 3'b000 || bus.result !== 16'sd0) begin
      bad++;
      $display("[TB] FAIL reset_state got rdy=%b ov=%b cs=%b addr=%b res=%0d want 1 0 0 000 0",
               bus.in_ready, bus.out_valid, bus.rom_cs, bus.rom_addr, bus.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic signed [15:0] expRound;
`ifdef DA_ROW_ACCUM_ROUND_EN
    expRound = 16'sd1;
`else
    expRound = 16'sd0;
`endif
    runSet(16'sd0,      16'sd0, 16'sd0,      16'sd16384,  -16'sd15137, 0, 1'b0);
    runSet(16'sd16384,  16'sd0, 16'sd0,      16'sd16384,  16'sd15137,  0, 1'b0);
    runSet(16'sd0,      16'sd0, 16'sd0,      16'sh8000,   16'sd30274,  0, 1'b0);
    runSet(16'sd0,      16'sd0, 16'sh8000,   16'sh8000,   16'sh7fff,   0, 1'b0);
    runSet(16'sh8000,   16'sd0, 16'sh8000,   16'sh8000,   16'sh8000,   0, 1'b0);
    runSet(16'sd1,      16'sd0, 16'sd0,      16'sd1,      expRound,    0, 1'b0);
  endtask

  task automatic test_random();
    logic signed [15:0] r0, r1, r2, r3;
    for (int i = 0; i < 10; i++) begin
      r0 = 16'($urandom); r1 = 16'($urandom); r2 = 16'($urandom); r3 = 16'($urandom);
      if (i % 3 == 0) r0 = '0;
      runSet(r0, r1, r2, r3, modelResult(r0, r1, r2, r3), $urandom_range(0, 3), 1'b1);
    end
  endtask

  task automatic test_reset_mid_accum();
    runSet(16'sd0, 16'sd0, 16'sd0, 16'sd16384, -16'sd15137, 0, 1'b0);
    @(negedge clk);
    bus.x0 = 16'sd0; bus.x1 = 16'sh7fff; bus.x2 = 16'sd0; bus.x3 = 16'sh7fff;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    total++;
    if (bus.rom_cs !== 1'b1 || bus.rom_addr !== 3'b101) begin
      bad++; $display("[TB] FAIL pre_reset_j7 got cs=%b addr=%b want cs=1 addr=101", bus.rom_cs, bus.rom_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.rom_cs !== 1'b0 || bus.rom_addr !== 3'b000 ||
        bus.result !== 16'sd0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_reset got ov=%b cs=%b addr=%b res=%0d rdy=%b want 0 0 000 0 1",
               bus.out_valid, bus.rom_cs, bus.rom_addr, bus.result, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    runSet(16'sd16384, 16'sd0, 16'sd0, 16'sd16384, 16'sd15137, 5, 1'b0);
  endtask

  task automatic test_back_to_back();
    time prev;
    logic signed [15:0] r1, r2;
    for (int i = 0; i < 3; i++) begin
      r1 = 16'($urandom); r2 = 16'($urandom);
      prev = lastAccept;
      runSet(16'sd0, r1, r2, 16'sd100, modelResult(16'sd0, r1, r2, 16'sd100), 0, 1'b0);
      if (i > 0) begin
        total++;
        if (lastAccept - prev != 180) begin
          bad++; $display("[TB] FAIL period got=%0t want=180", lastAccept - prev);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_accum();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/da_row_accum.md
DA_ROW_ACCUM -- requirements
Module: da_row_accum

Interface
REQ-001 clk  input  1  single clock; all state on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  sample set x0..x3 valid.
REQ-004 in_ready  output  1  block can accept a sample set.
REQ-005 x0, x1, x2, x3  input  16 each  signed two's-complement samples.
REQ-006 rom_addr  output  3  DA ROM address {x1[j], x2[j], x3[j]}.
REQ-007 rom_cs  output  1  ROM chip select; high only in ACCUM.
REQ-008 rom_data  input  16  signed Q2.14 ROM word, combinational on rom_addr.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 result  output  16  signed coefficient.

Function
REQ-012 FSM states IDLE, ACCUM, DONE; reset state IDLE.
REQ-013 IDLE: in_ready=1; in_valid=1 latches x0..x3, clears acc (32-bit signed) and j=0, goes to ACCUM.
REQ-014 ACCUM: rom_cs=1, rom_addr={x1[j],x2[j],x3[j]}; term = rom_data, negated when x0[j]=1.
REQ-015 j=0..14: acc += sign-extended term <<< j; j=15 (sign plane): acc -= term <<< 15.
REQ-016 ACCUM lasts exactly 16 cycles; after j=15, go to DONE.
REQ-017 DONE: out_valid=1, result registered and stable until out_valid && out_ready; then IDLE.
REQ-018 Latency: in_valid accept edge to out_valid high = 17 cycles; throughput one set per 18 cycles with out_ready=1.
REQ-019 result = acc[29:14] (arithmetic shift by 14), saturated to [-32768, 32767].
REQ-020 in_ready=0 in ACCUM and DONE; in_valid there ignored, latched samples unchanged.
REQ-021 rom_addr=0 and rom_cs=0 outside ACCUM.
REQ-022 out_ready while out_valid=0 has no effect.

Reset
REQ-023 rst_n low at any time, including mid-ACCUM: immediately state=IDLE, acc=0, j=0, result=0, out_valid=0, rom_cs=0, rom_addr=0, in_ready=1 after release.
REQ-024 First accept possible on first rising edge with rst_n high.

Configuration
REQ-025 Macro DA_ROW_ACCUM_ROUND_EN defined: add 2^13 to acc before the shift of REQ-019 (round half up), then saturate.
REQ-026 Macro undefined: truncation (floor) per REQ-019; no other behaviour differs.

Structure
REQ-027 Shared package da_pkg: SAMPLE_W=16, ROM_W=16, ACC_W=32, FRAC_W=14, NPLANES=16, state enum type.
REQ-028 One sub-module, da_sat_round: combinational acc-to-result rounding/saturation; FSM and accumulator in top.

Verification
REQ-029 x0=0,x1=0,x2=0,x3=16384, ROM model -c2=-15137 at addr 001 -> result -15137, out_valid 17 cycles after accept.
REQ-030 x0=16384,x3=16384 (negate path) -> result +15137.
REQ-031 x3=-32768, others 0 (sign plane) -> result 30274.
REQ-032 x2=x3=-32768 (addr 011, -21407) -> acc 21407*2^15, result saturates to 32767.
REQ-033 x0=x3=1 -> result 0 without macro, 1 with DA_ROW_ACCUM_ROUND_EN.
REQ-034 rst_n pulsed at j=7, and out_ready held low 5 cycles in DONE -> reset clears all outputs; held result stable, in_ready=0 until handshake.
